// File: rtl/fourier_result_reader.sv
// fourier_result_reader
// Reads the N result bins out of the Fourier top once it reports done.
// For each bin the address is driven, RD_LAT cycles are allowed for the
// read data to settle, and the signed result is captured. The result is then
// presented on a valid/ready stream tagged with its bin index. The largest
// magnitude seen so far is tracked alongside.
// Losing fft_done while a bin is being read or presented abandons the sweep.

module fourier_result_reader #(
   parameter int N      = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              fft_done,
   output logic [31:0]       reg_addr,
   input  logic [DATA_W-1:0] reg_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              finished,
   output logic              aborted,
   output logic [31:0]       peak_idx,
   output logic [DATA_W-1:0] peak_mag
);

   // The latency counter has to hold RD_LAT itself.
   localparam int CNT_W = $clog2(RD_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [31:0]      LAST_BIN = 32'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DONE,
      LAT,
      PRESENT,
      DONE_S
   } state_t;

   state_t            state_reg, state_next;
   logic [31:0]       bin_reg, bin_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [31:0]       addr_reg, addr_next;
   logic              valid_reg, valid_next;
   logic [31:0]       idx_reg, idx_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic              busy_reg, busy_next;
   logic              fin_reg, fin_next;
   logic              abort_reg, abort_next;
   logic [31:0]       pidx_reg, pidx_next;
   logic [DATA_W-1:0] pmag_reg, pmag_next;

   // Magnitude of the incoming word as an unsigned value. Negating the most
   // negative code wraps back onto itself, which read as unsigned is exactly
   // 2^(DATA_W-1), so no extra bit or saturation is needed.
   logic [DATA_W-1:0] mag;

   assign mag = reg_data[DATA_W-1] ? (~reg_data + DATA_W'(1)) : reg_data;

   // State and datapath registers; reset puts every output at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         bin_reg   <= '0;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         valid_reg <= 1'b0;
         idx_reg   <= '0;
         data_reg  <= '0;
         busy_reg  <= 1'b0;
         fin_reg   <= 1'b0;
         abort_reg <= 1'b0;
         pidx_reg  <= '0;
         pmag_reg  <= '0;
      end else begin
         state_reg <= state_next;
         bin_reg   <= bin_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         valid_reg <= valid_next;
         idx_reg   <= idx_next;
         data_reg  <= data_next;
         busy_reg  <= busy_next;
         fin_reg   <= fin_next;
         abort_reg <= abort_next;
         pidx_reg  <= pidx_next;
         pmag_reg  <= pmag_next;
      end
   end

   // Next-state and next-output logic for the sweep sequencer.
   always_comb begin
      state_next = state_reg;
      bin_next   = bin_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      valid_next = valid_reg;
      idx_next   = idx_reg;
      data_next  = data_reg;
      busy_next  = busy_reg;
      pidx_next  = pidx_reg;
      pmag_next  = pmag_reg;
      // Status flags are single-cycle pulses unless re-asserted below.
      fin_next   = 1'b0;
      abort_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = WAIT_DONE;
               busy_next  = 1'b1;
               pmag_next  = '0;
               pidx_next  = '0;
               addr_next  = '0;
               bin_next   = '0;
            end
         end

         WAIT_DONE: begin
            if (fft_done) begin
               state_next = LAT;
               cnt_next   = LAT_LOAD;
            end
         end

         LAT: begin
            if (!fft_done) begin
               state_next = IDLE;
               valid_next = 1'b0;
               abort_next = 1'b1;
               busy_next  = 1'b0;
            end else if (cnt_reg == '0) begin
               // Read data has settled for this address: capture it.
               state_next = PRESENT;
               data_next  = reg_data;
               idx_next   = bin_reg;
               valid_next = 1'b1;
               // Strict compare so the earliest bin keeps a tied peak.
               if (mag > pmag_reg) begin
                  pmag_next = mag;
                  pidx_next = bin_reg;
               end
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
            end
         end

         PRESENT: begin
            // Losing fft_done wins over a simultaneous handshake, so that
            // beat is dropped rather than delivered.
            if (!fft_done) begin
               state_next = IDLE;
               valid_next = 1'b0;
               abort_next = 1'b1;
               busy_next  = 1'b0;
            end else if (out_ready) begin
               valid_next = 1'b0;
               if (bin_reg == LAST_BIN) begin
                  state_next = DONE_S;
               end else begin
                  state_next = LAT;
                  bin_next   = bin_reg + 32'd1;
                  addr_next  = bin_reg + 32'd1;
                  cnt_next   = LAT_LOAD;
               end
            end
         end

         DONE_S: begin
            // Address and peak results are left in place for the reader.
            state_next = IDLE;
            fin_next   = 1'b1;
            busy_next  = 1'b0;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign reg_addr  = addr_reg;
   assign out_valid = valid_reg;
   assign out_idx   = idx_reg;
   assign out_data  = data_reg;
   assign busy      = busy_reg;
   assign finished  = fin_reg;
   assign aborted   = abort_reg;
   assign peak_idx  = pidx_reg;
   assign peak_mag  = pmag_reg;

endmodule
